// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the segment scan display path.
//   SEG_W_DEF    : default segment word width (matches digit decoder output)
//   MAX_DIGITS   : widest digit-select vector the helper function produces
//   SEG_BLANK    : all-segments-off word
//   scan_state_e : per-slot display phase (BLANK gap, then SHOW)
//   dig_sel_mask : one-hot digit select with output polarity applied
package seg_scan_driver_pkg;

  localparam int SEG_W_DEF  = 9;
  localparam int MAX_DIGITS = 8;

  localparam logic [SEG_W_DEF-1:0] SEG_BLANK = '0;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // en=0 yields all digits inactive; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] dig_sel_mask(input logic [2:0] idx,
                                                          input logic       en,
                                                          input logic       active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh = en ? (MAX_DIGITS'(1) << idx) : '0;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit timebase for the scan driver.
//   clk, rst     : clock, synchronous active-high reset
//   idx_o        : digit currently being scanned
//   state_o      : BLANK during the first BLANK_CYC cycles of a slot, else SHOW
//   frame_end_o  : high on the last cycle of the last digit's slot
module seg_scan_timer
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  localparam int IW = $clog2(DIGITS),
  localparam int CW = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx_o,
  output scan_state_e   state_o,
  output logic          frame_end_o
);

  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  scan_state_e   state_q, state_d;

  // State is decoded from the next count so state_q always agrees with cnt_q.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    state_d = (cnt_d < BLANK_END) ? BLANK : SHOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign idx_o       = idx_q;
  assign state_o     = state_q;
  assign frame_end_o = (idx_q == IDX_MAX) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment display driver with shadow/active double buffer.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : write wr_data into shadow entry wr_addr (out-of-range ignored)
//   wr_addr    : shadow entry index
//   wr_data    : segment word, bit set = segment lit
//   commit     : request shadow->active copy at the next frame boundary
//   pending    : commit accepted, copy not yet done
//   seg_out    : registered segment bus
//   dig_sel    : registered one-hot digit enable, polarity per SEL_ACTIVE_LOW
//   frame_done : one-cycle pulse following the last digit's slot
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SEG_W          = SEG_W_DEF,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  localparam int AW = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [SEG_W-1:0]  wr_data,
  input  logic              commit,
  output logic              pending,
  output logic [SEG_W-1:0]  seg_out,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_done
);

  localparam logic [AW:0]        DIG_N    = (AW + 1)'(DIGITS);
  localparam logic [DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? '1 : '0;

  logic [AW-1:0] idx;
  scan_state_e   state;
  logic          frame_end;

  seg_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx_o      (idx),
    .state_o    (state),
    .frame_end_o(frame_end)
  );

  logic [DIGITS-1:0][SEG_W-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0][SEG_W-1:0] active_q, active_d;
  logic                         pending_q, pending_d;
  logic [SEG_W-1:0]             seg_q, seg_d;
  logic [DIGITS-1:0]            sel_q, sel_d;
  logic                         fdone_q;
  logic                         copy;
  logic                         show;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && ({1'b0, wr_addr} < DIG_N))
      shadow_d[wr_addr] = wr_data;

    // Copy from shadow_d so a write landing on the boundary cycle is included.
    // Whole-buffer copy at the boundary keeps every frame self-consistent.
    copy      = frame_end && (pending_q || commit);
    active_d  = copy ? shadow_d : active_q;
    pending_d = copy ? 1'b0 : (commit ? 1'b1 : pending_q);

    show  = (state == SHOW);
    seg_d = show ? active_q[idx] : SEG_W'(SEG_BLANK);
    sel_d = DIGITS'(dig_sel_mask(3'(idx), show, SEL_ACTIVE_LOW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      sel_q     <= SEL_IDLE;
      fdone_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      fdone_q   <= frame_end;
    end
  end

  assign pending    = pending_q;
  assign seg_out    = seg_q;
  assign dig_sel    = sel_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = D * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, commit;
  logic [1:0] wr_addr;
  logic [8:0] wr_data;
  logic       pending, frame_done;
  logic [8:0] seg_out;
  logic [3:0] dig_sel;

  logic       wr_en3, commit3;
  logic [1:0] wr_addr3;
  logic [8:0] wr_data3;
  logic       pending3, frame_done3;
  logic [8:0] seg_out3;
  logic [2:0] dig_sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SEG_W(9), .SCAN_DIV(SD), .BLANK_CYC(BC), .SEL_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .pending(pending), .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done));

  seg_scan_driver #(.DIGITS(3), .SEG_W(9), .SCAN_DIV(SD), .BLANK_CYC(BC), .SEL_ACTIVE_LOW(1'b1)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .commit(commit3),
    .pending(pending3), .seg_out(seg_out3), .dig_sel(dig_sel3), .frame_done(frame_done3));

  // Reference model: time since reset determines slot and digit by division.
  int         t;
  logic [8:0] m_shadow [D];
  logic [8:0] m_active [D];
  bit         m_pend;
  logic [8:0] exp_seg;
  logic [3:0] exp_sel;
  logic       exp_pend, exp_fd;
  int         m_ph, m_dg;
  bit         m_bnd;

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      for (int i = 0; i < D; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
      m_pend = 0; exp_seg = '0; exp_sel = 4'hF; exp_pend = 0; exp_fd = 0;
    end else begin
      m_ph  = t % SD;
      m_dg  = (t / SD) % D;
      m_bnd = (t % FR) == FR - 1;
      exp_seg = (m_ph < BC) ? 9'h0 : m_active[m_dg];
      exp_sel = (m_ph < BC) ? 4'hF : ~(4'b0001 << m_dg);
      if (wr_en && int'(wr_addr) < D) m_shadow[wr_addr] = wr_data;
      if (m_bnd && (m_pend || commit)) begin
        for (int i = 0; i < D; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
      end else if (commit) m_pend = 1;
      exp_pend = m_pend;
      exp_fd   = m_bnd;
      t++;
    end
  end

  // Digit / phase of the outputs currently visible (produced at cycle t-1).
  function automatic int vis_dig();
    return ((t - 1) / SD) % D;
  endfunction
  function automatic int vis_ph();
    return (t - 1) % SD;
  endfunction

  task automatic test_reset;
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; commit = 0;
    wr_en3 = 0; wr_addr3 = 0; wr_data3 = 0; commit3 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (seg_out !== 9'h0) begin errors++; $display("FAIL reset_seg: got %h expected 000", seg_out); end
    checks++;
    if (dig_sel !== 4'hF) begin errors++; $display("FAIL reset_sel: got %b expected 1111", dig_sel); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", pending); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    rst = 0;
  endtask

  task automatic test_idle;
    int fd_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL idle: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
      checks++;
      if (seg_out !== 9'h0) begin errors++; $display("FAIL idle_seg: got %h expected 000", seg_out); end
      if (frame_done) fd_cnt++;
    end
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL idle_fd_count: got %0d expected 1", fd_cnt); end
  endtask

  task automatic test_load_commit;
    logic [8:0] vals [4];
    int n;
    vals[0] = 9'h06; vals[1] = 9'h5b; vals[2] = 9'h4f; vals[3] = 9'h66;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 2'(i); wr_data = vals[i];
      @(negedge clk);
    end
    wr_en = 0;
    repeat (FR) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL nocommit: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
    end
    commit = 1;
    @(negedge clk);
    commit = 0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL commit_pend: got %b expected 1", pending); end
    n = 0;
    while (frame_done !== 1'b1 && n < FR + 8) begin
      @(negedge clk); n++;
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL commit_wait: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL commit_timeout: frame_done=%b expected 1", frame_done); end
    repeat (FR) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL show_new: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
      for (int k = 0; k < 4; k++)
        if (dig_sel == ~(4'b0001 << k)) begin
          checks++;
          if (seg_out !== vals[k]) begin errors++; $display("FAIL digit%0d_value: got %h expected %h", k, seg_out, vals[k]); end
        end
    end
  endtask

  task automatic test_midframe_write;
    int n = 0;
    bit seen_fd = 0;
    while (!(vis_dig() == 1 && vis_ph() >= BC) && n < FR + 8) begin @(negedge clk); n++; end
    checks++;
    if (!(vis_dig() == 1 && vis_ph() >= BC)) begin errors++; $display("FAIL mid_wait: digit %0d expected 1", vis_dig()); end
    commit = 1; wr_en = 1; wr_addr = 2; wr_data = 9'h7f;
    @(negedge clk);
    commit = 0; wr_en = 0;
    repeat (2 * FR) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL midframe: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
      if (frame_done) seen_fd = 1;
      if (dig_sel == 4'b1011) begin
        checks++;
        if (seg_out !== (seen_fd ? 9'h7f : 9'h4f)) begin
          errors++; $display("FAIL mid_digit2: got %h expected %h", seg_out, seen_fd ? 9'h7f : 9'h4f);
        end
      end
    end
  endtask

  task automatic test_boundary;
    int n = 0;
    while ((t % FR) != FR - 2 && n < FR + 2) begin @(negedge clk); n++; end
    commit = 1;
    @(negedge clk);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL bnd_pend_set: got %b expected 1", pending); end
    wr_en = 1; wr_addr = 0; wr_data = 9'h3f;
    @(negedge clk);
    commit = 0; wr_en = 0;
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL bnd_pend_clr: got %b expected 0", pending); end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL bnd_fd: got %b expected 1", frame_done); end
    repeat (FR) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL boundary: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
      if (dig_sel == 4'b1110) begin
        checks++;
        if (seg_out !== 9'h3f) begin errors++; $display("FAIL bnd_digit0: got %h expected 03f", seg_out); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    while (!(vis_dig() == 2 && vis_ph() == BC) && n < FR + 8) begin @(negedge clk); n++; end
    checks++;
    if (!(vis_dig() == 2 && vis_ph() == BC)) begin errors++; $display("FAIL rmid_wait: digit %0d expected 2", vis_dig()); end
    commit = 1;
    @(negedge clk);
    commit = 0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL rmid_pend: got %b expected 1", pending); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({seg_out, dig_sel, pending} !== {9'h0, 4'hF, 1'b0}) begin
      errors++; $display("FAIL rmid_outputs: got seg=%h sel=%b pend=%b expected 000 1111 0", seg_out, dig_sel, pending);
    end
    repeat (40) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL rmid_scan: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
      checks++;
      if (seg_out !== 9'h0) begin errors++; $display("FAIL rmid_zero: got %h expected 000", seg_out); end
    end
  endtask

  task automatic test_random;
    repeat (400) begin
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel, pending, frame_done} !== {exp_seg, exp_sel, exp_pend, exp_fd}) begin
        errors++;
        $display("FAIL random: got seg=%h sel=%b pend=%b fd=%b expected seg=%h sel=%b pend=%b fd=%b",
                 seg_out, dig_sel, pending, frame_done, exp_seg, exp_sel, exp_pend, exp_fd);
      end
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 9'($urandom);
      commit  = ($urandom_range(0, 15) == 0);
    end
    wr_en = 0; commit = 0;
  endtask

  task automatic test_out_of_range;
    logic [8:0] v [3];
    int shown = 0;
    for (int i = 0; i < 3; i++) v[i] = 9'($urandom_range(1, 511));
    for (int i = 0; i < 3; i++) begin
      wr_en3 = 1; wr_addr3 = 2'(i); wr_data3 = v[i];
      @(negedge clk);
    end
    wr_en3 = 0; commit3 = 1;
    @(negedge clk);
    commit3 = 0;
    repeat (3 * 3 * SD) @(negedge clk);
    wr_en3 = 1; wr_addr3 = 2'd3; wr_data3 = ~v[0]; commit3 = 1;
    @(negedge clk);
    wr_en3 = 0; commit3 = 0;
    repeat (3 * 3 * SD) @(negedge clk);
    repeat (2 * 3 * SD) begin
      @(negedge clk);
      if (dig_sel3 != 3'b111) begin
        shown++;
        checks++;
        if (dig_sel3 != 3'b110 && dig_sel3 != 3'b101 && dig_sel3 != 3'b011) begin
          errors++; $display("FAIL oor_sel: got %b expected one-cold", dig_sel3);
        end
        for (int k = 0; k < 3; k++)
          if (dig_sel3 == ~(3'b001 << k)) begin
            checks++;
            if (seg_out3 !== v[k]) begin errors++; $display("FAIL oor_digit%0d: got %h expected %h", k, seg_out3, v[k]); end
          end
      end else begin
        checks++;
        if (seg_out3 !== 9'h0) begin errors++; $display("FAIL oor_blank: got %h expected 000", seg_out3); end
      end
    end
    checks++;
    if (shown != 2 * 3 * (SD - BC)) begin errors++; $display("FAIL oor_show_count: got %0d expected %0d", shown, 2 * 3 * (SD - BC)); end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_load_commit;
    test_midframe_write;
    test_boundary;
    test_reset_mid;
    test_random;
    test_out_of_range;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Physical-display end of the segment-code path: accepts per-digit 9-bit segment words from the digit decoders and time-multiplexes them onto the shared segment bus and digit-select lines of the board's multi-digit 7-segment display.
- Provides a shadow/active double buffer with a commit handshake so frames never tear, plus a blanking gap between digits to suppress ghosting.
- Sits between the piano's note/score decoders and the top-level display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8)
- SEG_W, 9, segment word width, bit-compatible with decoder outputs
- SCAN_DIV, 50000, clk cycles per digit slot (BLANK_CYC+1..2^20)
- BLANK_CYC, 500, cycles at start of each slot with all digits off (1..SCAN_DIV-1)
- SEL_ACTIVE_LOW, 1, 1 means dig_sel active level is 0

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write wr_data into shadow buffer entry wr_addr
- wr_addr  in  $clog2(DIGITS)  shadow entry index
- wr_data  in  SEG_W  segment word (bit set = segment lit)
- commit  in  1  request shadow→active copy at next frame boundary
- pending  out  1  commit accepted, copy not yet done
- seg_out  out  SEG_W  registered segment bus
- dig_sel  out  DIGITS  registered one-hot digit enable (polarity per SEL_ACTIVE_LOW)
- frame_done  out  1  one-cycle pulse at end of last digit's slot

Behaviour:
- Reset (sync, rst high at a clk edge): shadow and active buffers = 0; idx = 0; cnt = 0; state = BLANK; seg_out = 0; dig_sel = all inactive (all 1s when SEL_ACTIVE_LOW); pending = 0; frame_done = 0. Reset mid-frame abandons the frame and discards any pending commit.
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps. At the wrap, idx advances modulo DIGITS.
- FSM has two states.
  - BLANK while cnt < BLANK_CYC: next outputs are seg_out = 0 and dig_sel all inactive.
  - SHOW while cnt >= BLANK_CYC: next outputs are seg_out = active[idx] and dig_sel with only bit idx active.
  - Outputs are registered, one cycle after cnt/idx.
- Writes: when wr_en=1 and wr_addr < DIGITS, shadow[wr_addr] <= wr_data. Out-of-range addresses are ignored. Writes are allowed at any time and never affect the display directly.
- Commit: commit=1 sets pending=1. A repeated commit while pending is absorbed (single copy).
- Frame boundary is the cycle where idx=DIGITS-1 and cnt=SCAN_DIV-1.
  - On that cycle, if pending=1 (or commit=1 on that same cycle): active <= shadow (all entries at once) and pending <= 0.
  - A write on the same cycle as the copy is included in the copied data.
  - frame_done = 1 for exactly that cycle, registered, so it is visible the following cycle.
- Digit 0 of the next frame always shows the new data. No frame ever mixes old and new entries.
- Latency from commit to first visible new digit: at most one full frame + BLANK_CYC + 1 cycles.
- Widths: cnt is $clog2(SCAN_DIV) bits and idx is $clog2(DIGITS) bits. There is no arithmetic on segment data.

Decomposition:
- Shared display package holds:
  - SEG_W default
  - the SEG_BLANK constant (all zeros)
  - the state enum {BLANK, SHOW}
  - a function returning the one-hot digit select with polarity applied
- One natural sub-module, seg_scan_timer: owns cnt/idx, the state decode, and the frame-boundary strobe. The parent owns the buffers, commit logic and output registers.

Test Plan (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, SEL_ACTIVE_LOW=1):
- Reset, then idle 40 cycles → seg_out=0 throughout. dig_sel=4'b1111 for blank cycles; in SHOW cycles dig_sel cycles 1110,1101,1011,0111 for 6 cycles each. frame_done pulses every 32 cycles.
- Write 9'h06,9'h5b,9'h4f,9'h66 to addrs 0..3, no commit → display stays 0. Then commit → pending=1 until the boundary, then digits show 06,5b,4f,66 in order from the next frame's digit 0.
- Write addr 2 = 9'h7f mid-frame after a commit while digit 1 is showing → digits 2,3 of the current frame still show old values; the next frame shows 7f on digit 2.
- Commit and write addr 0 = 9'h3f on the exact boundary cycle → next frame digit 0 shows 3f; pending returns to 0 one cycle later.
- Assert rst for 1 cycle during SHOW of digit 2 with pending=1 → next cycle seg_out=0, dig_sel=1111, pending=0. The scan restarts from digit 0 with all-zero active data.
- wr_en with wr_addr out of range (DIGITS=3 build, addr=3) → no buffer change. The display after commit is unchanged.
